// File: rtl/seq_addsub_slice_pkg.sv
// Shared definitions for the slice-serial adder/subtractor.
package seq_addsub_slice_pkg;

    // Default datapath geometry.
    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_SLICE = 2;
    localparam int unsigned SLICE_COUNT   = DEFAULT_WIDTH / DEFAULT_SLICE;

    // Control FSM encoding.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Width of the slice index counter; at least one bit so a single-slice
    // configuration still has a legal vector.
    function automatic int unsigned idx_width(input int unsigned slice_count);
        return (slice_count > 1) ? $clog2(slice_count) : 1;
    endfunction

    localparam int unsigned IDX_W = idx_width(SLICE_COUNT);

endpackage

// File: rtl/seq_addsub_slice_cla.sv
// Combinational SLICE-bit carry-lookahead adder used once per cycle.
module seq_addsub_slice_cla
    import seq_addsub_slice_pkg::*;
#(
    parameter int unsigned SLICE = DEFAULT_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             c_top
);

    logic [SLICE-1:0] p;
    logic [SLICE-1:0] g;
    logic [SLICE:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // Each carry is the flat OR of generate terms gated by the propagates
    // above them, so no carry depends on a neighbouring carry.
    always_comb begin
        logic prod;
        c    = '0;
        prod = 1'b0;
        c[0] = cin;
        for (int i = 0; i < int'(SLICE); i++) begin
            c[i+1] = g[i];
            prod   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (prod & g[j]);
                prod   = prod & p[j];
            end
            c[i+1] = c[i+1] | (prod & cin);
        end
    end

    assign sum   = p ^ c[SLICE-1:0];
    assign cout  = c[SLICE];
    assign c_top = c[SLICE-1];

endmodule

// File: rtl/seq_addsub_slice.sv
// Multi-cycle adder/subtractor: one SLICE-bit chunk per cycle, carry held
// in a register between cycles, start/done handshake.
module seq_addsub_slice
    import seq_addsub_slice_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned SLICE = DEFAULT_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned N     = WIDTH / SLICE;
    localparam int unsigned IDXW  = idx_width(N);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;

    logic [SLICE-1:0] sl_a, sl_b, sl_sum;
    logic             sl_cout, sl_c_top;

    assign sl_a = a_q[int'(idx_q)*SLICE +: SLICE];
    assign sl_b = b_q[int'(idx_q)*SLICE +: SLICE];

    seq_addsub_slice_cla #(
        .SLICE (SLICE)
    ) u_cla (
        .a     (sl_a),
        .b     (sl_b),
        .cin   (carry_q),
        .sum   (sl_sum),
        .cout  (sl_cout),
        .c_top (sl_c_top)
    );

    // Next-state logic: accept in IDLE/DONE, one slice per RUN cycle.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    // Subtraction as a + ~b + 1: invert b, carry-in of 1.
                    a_d         = a;
                    b_d         = b ^ {WIDTH{op_sub}};
                    carry_d     = op_sub;
                    idx_d       = '0;
                    result_d    = '0;
                    carry_out_d = 1'b0;
                    overflow_d  = 1'b0;
                    zero_d      = 1'b0;
                    state_d     = StRun;
                end
            end
            StRun: begin
                result_d[int'(idx_q)*SLICE +: SLICE] = sl_sum;
                carry_d = sl_cout;
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    carry_out_d = sl_cout;
                    overflow_d  = sl_c_top ^ sl_cout;
                    zero_d      = (result_d == '0);
                    state_d     = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_seq_addsub_slice.sv
// Directed self-checking bench for seq_addsub_slice (WIDTH=32, SLICE=2).
module tb_seq_addsub_slice;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op_sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        carry_out;
    logic        overflow;
    logic        zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_addsub_slice #(
        .WIDTH (32),
        .SLICE (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    // Present a start for one edge; returns 1ns after the accepting edge.
    task automatic issue(input logic sub, input logic [31:0] x, input logic [31:0] y);
        @(posedge clk); #1;
        start = 1'b1; op_sub = sub; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done; lat counts edges after acceptance.
    task automatic wait_done(output int lat, output int busy_n);
        lat = 0; busy_n = 0;
        while (!done && lat < 100) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({busy, done, result, carry_out, overflow, zero} !== 36'd0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b res=%h c=%b v=%b z=%b want all 0",
                     busy, done, result, carry_out, overflow, zero);
        end
    endtask

    // Run one operation and check result, flags and timing.
    task automatic test_op(input string name, input logic sub, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] exp_r,
                           input logic exp_c, input logic exp_v, input logic exp_z);
        int lat, bn;
        issue(sub, x, y);
        wait_done(lat, bn);
        total++;
        if (lat !== 16) begin
            bad++;
            $display("FAIL %s_latency: got %0d edges want 16", name, lat);
        end
        total++;
        if (bn !== 16) begin
            bad++;
            $display("FAIL %s_busy_cycles: got %0d want 16", name, bn);
        end
        total++;
        if ({result, carry_out, overflow, zero} !== {exp_r, exp_c, exp_v, exp_z}) begin
            bad++;
            $display("FAIL %s_value: got res=%h c=%b v=%b z=%b want res=%h c=%b v=%b z=%b",
                     name, result, carry_out, overflow, zero, exp_r, exp_c, exp_v, exp_z);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || result !== exp_r || carry_out !== exp_c) begin
            bad++;
            $display("FAIL %s_hold: got done=%b res=%h c=%b want done=0 res=%h c=%b",
                     name, done, result, carry_out, exp_r, exp_c);
        end
    endtask

    task automatic test_start_in_run();
        int lat, bn;
        issue(1'b0, 32'd3, 32'd4);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; op_sub = 1'b1; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bn);
        lat = lat + 6;
        total++;
        if (lat !== 16 || result !== 32'd7) begin
            bad++;
            $display("FAIL ignored_start: got lat=%0d res=%h want lat=16 res=00000007",
                     lat, result);
        end
    endtask

    task automatic test_mid_reset();
        int seen;
        issue(1'b0, 32'd5, 32'd6);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({busy, done, result, carry_out, overflow, zero} !== 36'd0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b res=%h c=%b v=%b z=%b want 0",
                     busy, done, result, carry_out, overflow, zero);
        end
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL mid_reset_no_done: got %0d active cycles want 0", seen);
        end
        test_op("after_reset_1p1", 1'b0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        issue(1'b1, 32'd10, 32'd3);
        wait_done(lat, bn);
        total++;
        if (done !== 1'b1 || result !== 32'd7 || carry_out !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first: got done=%b res=%h c=%b want done=1 res=00000007 c=1",
                     done, result, carry_out);
        end
        // Start the next operation within the DONE cycle.
        start = 1'b1; op_sub = 1'b0; a = 32'd1; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_no_gap: got busy=%b done=%b want busy=1 done=0", busy, done);
        end
        wait_done(lat, bn);
        total++;
        if (lat !== 16 || result !== 32'd3 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second: got lat=%0d res=%h c=%b want lat=16 res=00000003 c=0",
                     lat, result, carry_out);
        end
    endtask

    initial begin
        test_reset();
        test_op("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        test_op("sub_borrow", 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        test_op("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        test_op("sub_ovf", 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        test_op("add_mixed", 1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 32'h2143_6587, 1'b0, 1'b0, 1'b0);
        test_start_in_run();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
